// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with single-cycle MULT/MULTU/MTHI/MTLO and a 32-step
// restoring radix-2 divider for DIV/DIVU that stalls the pipeline while busy.
module hilo_muldiv_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_done_o,
  output logic [1:0]  state_o
);

  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   quo_q;     // dividend shifts out the top, quotient bits shift in the bottom
  logic [31:0]   dvs_q;
  logic [31:0]   rem_q;
  logic [31:0]   a_raw_q;
  logic [CW-1:0] cnt_q;
  logic          div_zero_q, neg_q_q, neg_r_q;

  logic        accept, is_div, is_signed;
  logic [31:0] abs_a, abs_b;
  logic [63:0] prod_s, prod_u;
  logic [32:0] rem_sh, diff;
  logic        q_bit;
  logic [31:0] rem_nx, q_fix, r_fix;

  assign accept    = en_i && !flush_i && (state == IDLE);
  assign is_signed = (aluop_i == EXE_DIV_OP);
  assign is_div    = is_signed || (aluop_i == EXE_DIVU_OP);

  assign abs_a = (is_signed && src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
  assign abs_b = (is_signed && src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;

  // Low 64 bits of a 64x64 product of the extended operands give the exact result.
  assign prod_s = {{32{src_a_i[31]}}, src_a_i} * {{32{src_b_i[31]}}, src_b_i};
  assign prod_u = {32'd0, src_a_i} * {32'd0, src_b_i};

  // The shifted partial remainder needs 33 bits; the kept remainder never exceeds the divisor.
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign q_bit  = ~diff[32];
  assign rem_nx = q_bit ? diff[31:0] : rem_sh[31:0];

  assign q_fix = neg_q_q ? (~quo_q + 32'd1) : quo_q;
  assign r_fix = neg_r_q ? (~rem_q + 32'd1) : rem_q;

  assign stall_o    = resetn && (((state == IDLE) && accept && is_div) ||
                                 ((state == BUSY) && !flush_i));
  assign div_done_o = (state == DONE) && !flush_i;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign state_o    = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
      rem_q      <= 32'd0;
      a_raw_q    <= 32'd0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (aluop_i)
              EXE_MTHI_OP:  hi_q <= src_a_i;
              EXE_MTLO_OP:  lo_q <= src_a_i;
              EXE_MULT_OP:  {hi_q, lo_q} <= prod_s;
              EXE_MULTU_OP: {hi_q, lo_q} <= prod_u;
              EXE_DIV_OP, EXE_DIVU_OP: begin
                div_zero_q <= (src_b_i == 32'd0);
                neg_q_q    <= is_signed && (src_a_i[31] ^ src_b_i[31]);
                neg_r_q    <= is_signed && src_a_i[31];
                a_raw_q    <= src_a_i;
                quo_q      <= abs_a;
                dvs_q      <= abs_b;
                rem_q      <= 32'd0;
                cnt_q      <= '0;
                state      <= BUSY;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (flush_i) begin
            state <= IDLE;
            cnt_q <= '0;
          end else begin
            rem_q <= rem_nx;
            quo_q <= {quo_q[30:0], q_bit};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DIV_CYCLES - 1)) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!flush_i) begin
            if (div_zero_q) begin
              hi_q <= a_raw_q;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage consumer of the main decoder's `write_hilo` and `aluop` outputs.
- Owns the architectural HI/LO register pair.
- Executes MULT, MULTU, MTHI and MTLO in a single cycle.
- Executes DIV and DIVU on an iterative radix-2 divider that stalls the pipeline until the result is written.
- Drives `hi_o`/`lo_o` for MFHI/MFLO in the execute stage.

Parameters:
- DIV_CYCLES, 32, number of divider iterations (one quotient bit per cycle); fixed at 32 for 32-bit operands.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- en_i  input  1  execute-stage instruction valid AND `write_hilo`.
- aluop_i  input  8  ALU op code; `EXE_*_OP` encodings from defines.vh.
- src_a_i  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- src_b_i  input  32  rt operand: multiplier or divisor.
- flush_i  input  1  execute-stage flush (exception or redirect).
- stall_o  output  1  hold request to the hazard unit; stalls fetch, decode and execute.
- hi_o  output  32  current HI register.
- lo_o  output  32  current LO register.
- div_done_o  output  1  one-cycle pulse when a divide result is written.

Behaviour:
- Reset (resetn=0, asynchronous):
  - hi=0, lo=0, state=IDLE, counter=0.
  - stall_o=0, div_done_o=0.
- States: IDLE, BUSY, DONE.
- Accepted op: en_i=1, flush_i=0 and state=IDLE. An aluop that is not a HI/LO op is ignored even when en_i=1.
- MTHI: hi<=src_a_i at the next edge; lo unchanged.
- MTLO: lo<=src_a_i at the next edge; hi unchanged.
- MULT: {hi,lo}<=signed 32x32 to 64-bit product at the next edge.
- MULTU: as MULT, unsigned product.
- Single-cycle ops never assert stall_o.
- DIV/DIVU issue cycle:
  - stall_o=1 combinationally in the issue cycle.
  - At the edge: latch divisor-zero flag and both operand signs (DIV only).
  - Latch |a| and |b| (DIV) or raw operands (DIVU).
  - Clear the 33-bit partial remainder; counter<=0; state<=BUSY.
- BUSY:
  - stall_o=1.
  - Each cycle: one restoring shift-subtract step; counter++.
  - When counter reaches DIV_CYCLES-1, state<=DONE at that edge.
  - en_i, aluop_i and operands are ignored while BUSY; the pipeline holds them stable.
- DONE:
  - stall_o=0; div_done_o=1.
  - At the edge: hi<=remainder, lo<=quotient after sign fixup; state<=IDLE.
  - The same held instruction is still presented on en_i during DONE and must not restart a divide.
- Latency: issue cycle T, BUSY T+1..T+32, DONE T+33. stall_o is high for 33 cycles. The new HI/LO is visible on hi_o/lo_o from T+34.
- Sign fixup (DIV):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV and DIVU): lo=32'hFFFF_FFFF, hi=src_a_i as latched; no sign fixup.
- Overflow (DIV, 32'h8000_0000 / 32'hFFFF_FFFF): lo=32'h8000_0000, hi=0.
- flush_i:
  - IDLE: suppresses any write.
  - BUSY or DONE: aborts the divide; state<=IDLE; HI/LO unchanged; div_done_o=0.
  - stall_o goes low in the flush cycle.
- hi_o/lo_o are the register outputs. Same-cycle MFHI forwarding is not done here; the hazard unit owns it.
- Reset asserted mid-divide: returns immediately to IDLE; HI/LO=0.

Test Plan:
- MTHI src_a=32'h1234_5678, then MTLO src_a=32'hCAFE_0001 → hi_o=32'h1234_5678, lo_o=32'hCAFE_0001 one cycle after each op; stall_o never 1.
- MULT a=32'hFFFF_FFFE (-2), b=3 → {hi,lo}=64'hFFFF_FFFF_FFFF_FFFA next cycle. MULTU with the same operands → hi=32'h0000_0002, lo=32'hFFFF_FFFA.
- DIV a=-7 (32'hFFFF_FFF9), b=2 → stall_o high exactly 33 cycles; div_done_o pulses once; lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU 100/7 → lo=14, hi=2.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF → lo=32'h8000_0000, hi=0.
- DIVU 5/0 → lo=32'hFFFF_FFFF, hi=5.
- Start DIV, pulse flush_i at BUSY cycle 10 → stall_o low in the flush cycle; HI/LO keep their prior values; no div_done_o.
- Start DIV, assert resetn=0 at BUSY cycle 5 → stall_o=0 and hi_o=lo_o=0 immediately (asynchronous).
- Hold en_i high through DONE → no second divide is started.
